// File: rtl/hc05_spi_pkg.sv
// rtl/hc05_spi_pkg.sv - register map, bit positions, FSM states and SPR divider table
package hc05_spi_pkg;

   localparam logic [1:0] REG_SPCR = 2'd0;
   localparam logic [1:0] REG_SPSR = 2'd1;
   localparam logic [1:0] REG_SPDR = 2'd2;

   localparam int SPCR_SPIE = 7;
   localparam int SPCR_SPE  = 6;
   localparam int SPCR_MSTR = 4;
   localparam int SPCR_CPOL = 3;
   localparam int SPCR_CPHA = 2;

   localparam int SPSR_SPIF = 7;
   localparam int SPSR_WCOL = 6;
   localparam int SPSR_MODF = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } spi_state_e;

   localparam logic [5:0] SPR_DIV [4] = '{6'd2, 6'd4, 6'd16, 6'd32};

   // A byte takes eight bit times, so the load value is the divider times 8.
   function automatic logic [8:0] xfer_ticks(input logic [1:0] spr, input logic fast);
      logic [5:0] div;
      div = SPR_DIV[spr];
      if (fast) begin
         return 9'd8;
      end
      return {div, 3'b000};
   endfunction

endpackage

// File: rtl/hc05_spi_master_if.sv
// rtl/hc05_spi_master_if.sv - parallel byte link between the SPI master and the servo stage
interface parallelel_spi;

   logic       write;
   logic [7:0] mosi;
   logic [7:0] miso;

   modport master (output write, output mosi, input miso);
   modport slave  (input write, input mosi, output miso);

endinterface

// File: rtl/spi_bit_timer.sv
// rtl/spi_bit_timer.sv - ce-tick down-counter that flags the last tick of a byte transfer
module spi_bit_timer
   import hc05_spi_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ce,
   input  logic       load,
   input  logic [1:0] spr,
   input  logic       fast_sim,
   output logic       done
);

   logic [8:0] count_q;

   // SPR is only sampled at load, so reprogramming mid-transfer leaves the count alone.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= 9'd0;
      end else if (load) begin
         count_q <= xfer_ticks(spr, fast_sim);
      end else if (ce && (count_q != 9'd0)) begin
         count_q <= count_q - 9'd1;
      end
   end

   assign done = ce && !load && (count_q == 9'd1);

endmodule

// File: rtl/hc05_spi_master.sv
// rtl/hc05_spi_master.sv - HC05-style SPI master: SPCR/SPSR/SPDR registers driving a byte-wide servo link
module hc05_spi_master
   import hc05_spi_pkg::*;
#(
   parameter int FAST_SIM = 0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         ce,
   input  logic         cs,
   input  logic         we,
   input  logic [1:0]   reg_sel,
   input  logic [7:0]   wdata,
   output logic [7:0]   rdata,
   parallelel_spi.master spi,
   input  logic         mode_fault,
   output logic         irq
);

   spi_state_e state_q, state_d;

   logic       spie_q, spe_q, mstr_q, cpol_q, cpha_q;
   logic [1:0] spr_q;
   logic       spif_q, wcol_q, modf_q;
   logic       spif_arm_q, wcol_arm_q, modf_arm_q;
   logic [7:0] tx_q, rx_q;

   logic       wr_spcr, rd_spsr, acc_spdr, wr_spdr;
   logic       fault_hit, spcr_abort;
   logic       load, complete, done;
   logic [7:0] spcr_v, spsr_v;

   assign wr_spcr    = cs && we && (reg_sel == REG_SPCR);
   assign rd_spsr    = cs && !we && (reg_sel == REG_SPSR);
   assign acc_spdr   = cs && (reg_sel == REG_SPDR);
   assign wr_spdr    = acc_spdr && we;
   assign fault_hit  = mode_fault && mstr_q;
   assign spcr_abort = wr_spcr && (!wdata[SPCR_SPE] || !wdata[SPCR_MSTR]);

   spi_bit_timer u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .ce       (ce),
      .load     (load),
      .spr      (spr_q),
      .fast_sim (FAST_SIM != 0),
      .done     (done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Aborts (mode fault or SPE/MSTR dropped) take priority over a coincident completion.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wr_spdr && spe_q && mstr_q && !fault_hit) begin
               load    = 1'b1;
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (fault_hit || spcr_abort) begin
               state_d = ST_IDLE;
            end else if (done) begin
               complete = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign spi.write = complete;
   assign spi.mosi  = complete ? tx_q : 8'hFF;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spie_q     <= 1'b0;
         spe_q      <= 1'b0;
         mstr_q     <= 1'b0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         spr_q      <= 2'd0;
         spif_q     <= 1'b0;
         wcol_q     <= 1'b0;
         modf_q     <= 1'b0;
         spif_arm_q <= 1'b0;
         wcol_arm_q <= 1'b0;
         modf_arm_q <= 1'b0;
         tx_q       <= 8'h00;
         rx_q       <= 8'h00;
      end else begin
         if (wr_spcr) begin
            spie_q <= wdata[SPCR_SPIE];
            spe_q  <= wdata[SPCR_SPE];
            mstr_q <= wdata[SPCR_MSTR];
            cpol_q <= wdata[SPCR_CPOL];
            cpha_q <= wdata[SPCR_CPHA];
            spr_q  <= wdata[1:0];
            if (modf_arm_q) begin
               modf_q     <= 1'b0;
               modf_arm_q <= 1'b0;
            end
         end
         if (fault_hit) begin
            spe_q  <= 1'b0;
            mstr_q <= 1'b0;
            modf_q <= 1'b1;
         end

         // Flag clears are ordered before the sets so a same-clk set survives.
         if (acc_spdr && spif_arm_q) begin
            spif_q     <= 1'b0;
            spif_arm_q <= 1'b0;
         end
         if (acc_spdr && wcol_arm_q) begin
            wcol_q     <= 1'b0;
            wcol_arm_q <= 1'b0;
         end
         if (wr_spdr && (state_q == ST_IDLE)) begin
            tx_q <= wdata;
         end
         if (wr_spdr && (state_q == ST_XFER)) begin
            wcol_q <= 1'b1;
         end
         if (complete) begin
            spif_q <= 1'b1;
            rx_q   <= spi.miso;
         end

         if (rd_spsr) begin
            if (spif_q) spif_arm_q <= 1'b1;
            if (wcol_q) wcol_arm_q <= 1'b1;
            if (modf_q) modf_arm_q <= 1'b1;
         end
      end
   end

   always_comb begin
      spcr_v            = 8'h00;
      spcr_v[SPCR_SPIE] = spie_q;
      spcr_v[SPCR_SPE]  = spe_q;
      spcr_v[SPCR_MSTR] = mstr_q;
      spcr_v[SPCR_CPOL] = cpol_q;
      spcr_v[SPCR_CPHA] = cpha_q;
      spcr_v[1:0]       = spr_q;
      spsr_v            = 8'h00;
      spsr_v[SPSR_SPIF] = spif_q;
      spsr_v[SPSR_WCOL] = wcol_q;
      spsr_v[SPSR_MODF] = modf_q;
   end

   always_comb begin
      rdata = 8'hFF;
      case (reg_sel)
         REG_SPCR: rdata = spcr_v;
         REG_SPSR: rdata = spsr_v;
         REG_SPDR: rdata = rx_q;
         default:  rdata = 8'hFF;
      endcase
   end

   assign irq = spie_q && (spif_q || modf_q);

endmodule

// File: tb/tb_hc05_spi_master.sv
// tb/tb_hc05_spi_master.sv - scoreboard bench for hc05_spi_master
module tb_hc05_spi_master;
   import hc05_spi_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ce = 1'b0;
   logic       cs = 1'b0;
   logic       we = 1'b0;
   logic       mode_fault = 1'b0;
   logic [1:0] reg_sel = 2'd0;
   logic [7:0] wdata = 8'h00;
   logic [7:0] rdata;
   logic       irq;

   parallelel_spi spi_if();

   hc05_spi_master #(.FAST_SIM(0)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ce         (ce),
      .cs         (cs),
      .we         (we),
      .reg_sel    (reg_sel),
      .wdata      (wdata),
      .rdata      (rdata),
      .spi        (spi_if),
      .mode_fault (mode_fault),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         passes = 0;
   int         write_count = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   // Every write pulse must match the oldest byte queued when its transfer was started.
   always @(negedge clk) begin
      if (spi_if.write === 1'b1) begin
         write_count++;
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_write: got mosi %h, required no write", spi_if.mosi);
         end else begin
            mon_exp = exp_q.pop_front();
            if (spi_if.mosi !== mon_exp)
               $display("FAIL write_mosi: got %h required %h", spi_if.mosi, mon_exp);
            else
               passes++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [1:0] sel, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; reg_sel = sel; wdata = d;
      step();
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic cpu_read(input logic [1:0] sel, output logic [7:0] d);
      cs = 1'b1; we = 1'b0; reg_sel = sel;
      #2 d = rdata;
      step();
      cs = 1'b0;
   endtask

   task automatic ce_ticks(input int n);
      repeat (n) begin
         ce = 1'b1;
         step();
         ce = 1'b0;
         step();
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reg_sel = REG_SPSR;
      #1;
      checks++; if (rdata !== 8'h00) $display("FAIL reset_spsr: got %h required %h", rdata, 8'h00); else passes++;
      checks++; if (irq !== 1'b0 || spi_if.write !== 1'b0) $display("FAIL reset_outputs: got irq %b write %b required 0 0", irq, spi_if.write); else passes++;
      step();
      reset_n = 1'b1;
      step();
      cpu_read(REG_SPCR, d);
      checks++; if (d !== 8'h00) $display("FAIL reset_spcr: got %h required %h", d, 8'h00); else passes++;
      cpu_read(2'd3, d);
      checks++; if (d !== 8'hFF) $display("FAIL unmapped_read: got %h required %h", d, 8'hFF); else passes++;
      checks++; if (spi_if.mosi !== 8'hFF) $display("FAIL idle_mosi: got %h required %h", spi_if.mosi, 8'hFF); else passes++;
   endtask

   task automatic test_registers();
      logic [7:0] d;
      cpu_write(REG_SPCR, 8'hAF);
      cpu_read(REG_SPCR, d);
      checks++; if (d !== 8'h8F) $display("FAIL spcr_bit5: got %h required %h", d, 8'h8F); else passes++;
      cpu_write(REG_SPSR, 8'hFF);
      cpu_read(REG_SPSR, d);
      checks++; if (d !== 8'h00) $display("FAIL spsr_write_ignored: got %h required %h", d, 8'h00); else passes++;
      cpu_write(REG_SPCR, 8'h00);
   endtask

   task automatic test_basic();
      logic [7:0] d;
      int wc;
      cpu_write(REG_SPCR, 8'h50);
      spi_if.miso = 8'h55;
      exp_q.push_back(8'hB0);
      cpu_write(REG_SPDR, 8'hB0);
      wc = write_count;
      ce_ticks(15);
      checks++; if (write_count !== wc) $display("FAIL basic_early: got %0d writes required %0d", write_count - wc, 0); else passes++;
      ce_ticks(1);
      checks++; if (write_count !== wc + 1) $display("FAIL basic_on_time: got %0d writes required %0d", write_count - wc, 1); else passes++;
      cpu_read(REG_SPDR, d);
      checks++; if (d !== 8'h55) $display("FAIL basic_spdr: got %h required %h", d, 8'h55); else passes++;
      cpu_read(REG_SPSR, d);
      checks++; if (d !== 8'h80) $display("FAIL basic_spsr: got %h required %h", d, 8'h80); else passes++;
      cpu_read(REG_SPDR, d);
      cpu_read(REG_SPSR, d);
      checks++; if (d !== 8'h00) $display("FAIL basic_spif_clear: got %h required %h", d, 8'h00); else passes++;
   endtask

   task automatic test_slow_irq();
      logic [7:0] d;
      int wc;
      cpu_write(REG_SPCR, 8'hD3);
      spi_if.miso = 8'hC3;
      exp_q.push_back(8'hAA);
      cpu_write(REG_SPDR, 8'hAA);
      wc = write_count;
      ce_ticks(255);
      checks++; if (write_count !== wc) $display("FAIL slow_early: got %0d writes required %0d", write_count - wc, 0); else passes++;
      ce = 1'b1;
      #2;
      checks++; if (irq !== 1'b0) $display("FAIL slow_irq_during: got %b required %b", irq, 1'b0); else passes++;
      step();
      ce = 1'b0;
      checks++; if (write_count !== wc + 1) $display("FAIL slow_on_time: got %0d writes required %0d", write_count - wc, 1); else passes++;
      checks++; if (irq !== 1'b1) $display("FAIL slow_irq_after: got %b required %b", irq, 1'b1); else passes++;
      cpu_read(REG_SPSR, d);
      checks++; if (d !== 8'h80) $display("FAIL slow_spsr: got %h required %h", d, 8'h80); else passes++;
      cpu_read(REG_SPDR, d);
      checks++; if (d !== 8'hC3) $display("FAIL slow_spdr: got %h required %h", d, 8'hC3); else passes++;
      cpu_read(REG_SPSR, d);
      checks++; if (d !== 8'h00 || irq !== 1'b0) $display("FAIL slow_clear: got spsr %h irq %b required 00 0", d, irq); else passes++;
      cpu_write(REG_SPCR, 8'h00);
   endtask

   task automatic test_wcol();
      logic [7:0] d;
      cpu_write(REG_SPCR, 8'h50);
      exp_q.push_back(8'h3C);
      cpu_write(REG_SPDR, 8'h3C);
      ce_ticks(5);
      cpu_write(REG_SPDR, 8'h11);
      ce_ticks(11);
      cpu_read(REG_SPSR, d);
      checks++; if (d !== 8'hC0) $display("FAIL wcol_spsr: got %h required %h", d, 8'hC0); else passes++;
      cpu_read(REG_SPDR, d);
      cpu_read(REG_SPSR, d);
      checks++; if (d !== 8'h00) $display("FAIL wcol_clear: got %h required %h", d, 8'h00); else passes++;
   endtask

   task automatic test_mode_fault();
      logic [7:0] d;
      int wc;
      cpu_write(REG_SPCR, 8'h50);
      cpu_write(REG_SPDR, 8'h77);
      wc = write_count;
      ce_ticks(4);
      mode_fault = 1'b1;
      step();
      mode_fault = 1'b0;
      ce_ticks(20);
      checks++; if (write_count !== wc) $display("FAIL fault_no_write: got %0d writes required %0d", write_count - wc, 0); else passes++;
      cpu_read(REG_SPCR, d);
      checks++; if (d !== 8'h00) $display("FAIL fault_spcr: got %h required %h", d, 8'h00); else passes++;
      cpu_read(REG_SPSR, d);
      checks++; if (d !== 8'h10) $display("FAIL fault_spsr: got %h required %h", d, 8'h10); else passes++;
      cpu_write(REG_SPCR, 8'h50);
      cpu_read(REG_SPSR, d);
      checks++; if (d !== 8'h00) $display("FAIL fault_modf_clear: got %h required %h", d, 8'h00); else passes++;
      cpu_write(REG_SPCR, 8'h00);
   endtask

   task automatic test_fault_coincident();
      logic [7:0] d;
      int wc;
      cpu_write(REG_SPCR, 8'h50);
      cpu_write(REG_SPDR, 8'h99);
      wc = write_count;
      ce_ticks(15);
      ce = 1'b1;
      mode_fault = 1'b1;
      step();
      ce = 1'b0;
      mode_fault = 1'b0;
      step();
      checks++; if (write_count !== wc) $display("FAIL coincident_no_write: got %0d writes required %0d", write_count - wc, 0); else passes++;
      cpu_read(REG_SPSR, d);
      checks++; if (d !== 8'h10) $display("FAIL coincident_spsr: got %h required %h", d, 8'h10); else passes++;
      cpu_write(REG_SPCR, 8'h00);
   endtask

   task automatic test_no_master();
      logic [7:0] d;
      int wc;
      cpu_write(REG_SPCR, 8'h40);
      cpu_write(REG_SPDR, 8'h5A);
      wc = write_count;
      ce_ticks(20);
      mode_fault = 1'b1;
      step();
      mode_fault = 1'b0;
      checks++; if (write_count !== wc) $display("FAIL slave_no_xfer: got %0d writes required %0d", write_count - wc, 0); else passes++;
      cpu_read(REG_SPSR, d);
      checks++; if (d !== 8'h00) $display("FAIL slave_fault_ignored: got %h required %h", d, 8'h00); else passes++;
      cpu_read(REG_SPCR, d);
      checks++; if (d !== 8'h40) $display("FAIL slave_spcr: got %h required %h", d, 8'h40); else passes++;
      cpu_write(REG_SPCR, 8'h00);
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      int wc;
      cpu_write(REG_SPCR, 8'h51);
      wc = write_count;
      spi_if.miso = 8'h3E;
      exp_q.push_back(8'h01);
      cpu_write(REG_SPDR, 8'h01);
      ce_ticks(32);
      cpu_read(REG_SPDR, d);
      checks++; if (d !== 8'h3E) $display("FAIL b2b_rx1: got %h required %h", d, 8'h3E); else passes++;
      spi_if.miso = 8'h7D;
      exp_q.push_back(8'h02);
      cpu_write(REG_SPDR, 8'h02);
      ce_ticks(32);
      checks++; if (write_count !== wc + 2) $display("FAIL b2b_count: got %0d writes required %0d", write_count - wc, 2); else passes++;
      cpu_read(REG_SPDR, d);
      checks++; if (d !== 8'h7D) $display("FAIL b2b_rx2: got %h required %h", d, 8'h7D); else passes++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      int wc;
      cpu_write(REG_SPCR, 8'h50);
      cpu_write(REG_SPDR, 8'hE1);
      wc = write_count;
      ce_ticks(6);
      #2 reset_n = 1'b0;
      reg_sel = REG_SPCR;
      #1;
      checks++; if (rdata !== 8'h00) $display("FAIL async_reset_spcr: got %h required %h", rdata, 8'h00); else passes++;
      step();
      step();
      reset_n = 1'b1;
      ce_ticks(20);
      checks++; if (write_count !== wc) $display("FAIL reset_mid_no_write: got %0d writes required %0d", write_count - wc, 0); else passes++;
      cpu_read(REG_SPCR, d);
      checks++; if (d !== 8'h00) $display("FAIL reset_mid_spcr: got %h required %h", d, 8'h00); else passes++;
      cpu_read(REG_SPSR, d);
      checks++; if (d !== 8'h00) $display("FAIL reset_mid_spsr: got %h required %h", d, 8'h00); else passes++;
      cpu_read(REG_SPDR, d);
      checks++; if (d !== 8'h00) $display("FAIL reset_mid_spdr: got %h required %h", d, 8'h00); else passes++;
   endtask

   initial begin
      spi_if.miso = 8'h00;
      step();
      test_reset();
      test_registers();
      test_basic();
      test_slow_irq();
      test_wcol();
      test_mode_fault();
      test_fault_coincident();
      test_no_master();
      test_back_to_back();
      test_reset_mid();
      checks++; if (exp_q.size() != 0) $display("FAIL pending_writes: got %0d outstanding required %0d", exp_q.size(), 0); else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
